cmp_1bit: RTL and testbench

Registered single-bit magnitude comparator cell with a cascade input, so N cells can be chained most-significant-bit first into a multi-bit comparator. Each accepted sample yields exactly one of equal / more / less, one clock after acceptance. It is the leaf cell of the compare datapath; wider comparators instantiate one per bit and chain the cascade ports.

---
 rtl/cmp_1bit_if.sv | 23 ++
 rtl/cmp_1bit.sv | 119 +++++++++++
 tb/tb_cmp_1bit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cmp_1bit_if.sv
// Sample/result bundle for the cmp_1bit comparator cell.
// master drives operands and cascade bits; slave is the comparator cell itself.
interface cmp_1bit_if;
    logic in_valid;
    logic A;
    logic B;
    logic casc_more;
    logic casc_less;
    logic out_valid;
    logic equal;
    logic more;
    logic less;

    modport master (
        output in_valid, A, B, casc_more, casc_less,
        input  out_valid, equal, more, less
    );

    modport slave (
        input  in_valid, A, B, casc_more, casc_less,
        output out_valid, equal, more, less
    );
endinterface

// File: rtl/cmp_1bit.sv
// Registered 1-bit magnitude comparator cell with MSB-first cascade inputs.
// Optional saturating result counters are compiled in with CMP1BIT_STATS_EN.
module cmp_1bit #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cmp_1bit_if.slave            bus,
    input  logic                 clr_stats,
    output logic [CNT_WIDTH-1:0] eq_cnt,
    output logic [CNT_WIDTH-1:0] more_cnt,
    output logic [CNT_WIDTH-1:0] less_cnt
);

    logic loc_eq, loc_more, loc_less;
    logic res_eq, res_more, res_less;

    logic valid_q;
    logic equal_q, more_q, less_q;

    // A decided higher-order stage overrides the local bit; more wins a tie.
    always_comb begin
        loc_eq   = ~(bus.A ^ bus.B);
        loc_more = bus.A & ~bus.B;
        loc_less = ~bus.A & bus.B;
        res_eq   = 1'b0;
        res_more = 1'b0;
        res_less = 1'b0;
        if (bus.casc_more) begin
            res_more = 1'b1;
        end else if (bus.casc_less) begin
            res_less = 1'b1;
        end else begin
            res_eq   = loc_eq;
            res_more = loc_more;
            res_less = loc_less;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            equal_q <= 1'b0;
            more_q  <= 1'b0;
            less_q  <= 1'b0;
        end else if (bus.in_valid) begin
            equal_q <= res_eq;
            more_q  <= res_more;
            less_q  <= res_less;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.equal     = equal_q;
    assign bus.more      = more_q;
    assign bus.less      = less_q;

`ifdef CMP1BIT_STATS_EN
    logic [CNT_WIDTH-1:0] eq_cnt_q, more_cnt_q, less_cnt_q;
    logic [CNT_WIDTH-1:0] eq_cnt_d, more_cnt_d, less_cnt_d;

    // Saturate at all-ones; clear beats a same-cycle increment.
    always_comb begin
        eq_cnt_d   = eq_cnt_q;
        more_cnt_d = more_cnt_q;
        less_cnt_d = less_cnt_q;
        if (clr_stats) begin
            eq_cnt_d   = '0;
            more_cnt_d = '0;
            less_cnt_d = '0;
        end else if (bus.in_valid) begin
            if (res_eq && (eq_cnt_q != '1)) begin
                eq_cnt_d = eq_cnt_q + 1'b1;
            end
            if (res_more && (more_cnt_q != '1)) begin
                more_cnt_d = more_cnt_q + 1'b1;
            end
            if (res_less && (less_cnt_q != '1)) begin
                less_cnt_d = less_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eq_cnt_q   <= '0;
            more_cnt_q <= '0;
            less_cnt_q <= '0;
        end else begin
            eq_cnt_q   <= eq_cnt_d;
            more_cnt_q <= more_cnt_d;
            less_cnt_q <= less_cnt_d;
        end
    end

    assign eq_cnt   = eq_cnt_q;
    assign more_cnt = more_cnt_q;
    assign less_cnt = less_cnt_q;
`else
    logic unused_clr_stats;
    assign unused_clr_stats = clr_stats;

    assign eq_cnt   = '0;
    assign more_cnt = '0;
    assign less_cnt = '0;
`endif

    // Any qualified result must be exactly one of equal/more/less.
    assert property (@(posedge clk) disable iff (rst)
        valid_q |-> $onehot({equal_q, more_q, less_q}));

endmodule

// File: tb/tb_cmp_1bit.sv
// Randomized and directed self-checking bench for cmp_1bit, including a 2-cell chain.
module tb_cmp_1bit;
    localparam int unsigned CW = 2;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_stats = 1'b0;
    logic [CW-1:0] eq_cnt, more_cnt, less_cnt;

    always #5 clk = ~clk;

    cmp_1bit_if dut_if ();
    cmp_1bit_if hi_if ();
    cmp_1bit_if lo_if ();

    cmp_1bit #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .bus(dut_if), .clr_stats(clr_stats),
        .eq_cnt(eq_cnt), .more_cnt(more_cnt), .less_cnt(less_cnt)
    );

    logic [CW-1:0] unused_hi_eq, unused_hi_more, unused_hi_less;
    logic [CW-1:0] unused_lo_eq, unused_lo_more, unused_lo_less;

    cmp_1bit #(.CNT_WIDTH(CW)) u_hi (
        .clk(clk), .rst(rst), .bus(hi_if), .clr_stats(1'b0),
        .eq_cnt(unused_hi_eq), .more_cnt(unused_hi_more), .less_cnt(unused_hi_less)
    );

    cmp_1bit #(.CNT_WIDTH(CW)) u_lo (
        .clk(clk), .rst(rst), .bus(lo_if), .clr_stats(1'b0),
        .eq_cnt(unused_lo_eq), .more_cnt(unused_lo_more), .less_cnt(unused_lo_less)
    );

    // Low bit sees the high cell's registered result; tb delays its operands to match.
    assign lo_if.in_valid  = hi_if.out_valid;
    assign lo_if.casc_more = hi_if.more;
    assign lo_if.casc_less = hi_if.less;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: flags as {equal,more,less}, counters indexed eq/more/less.
    logic [2:0] exp_flags = 3'b000;
    logic       exp_valid = 1'b0;
    int         exp_cnt[3] = '{0, 0, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic a, input logic b,
                         input logic cm, input logic cl, input logic clr);
        dut_if.in_valid  = iv;
        dut_if.A         = a;
        dut_if.B         = b;
        dut_if.casc_more = cm;
        dut_if.casc_less = cl;
        clr_stats        = clr;
    endtask

    task automatic model_reset();
        exp_flags = 3'b000;
        exp_valid = 1'b0;
        exp_cnt   = '{0, 0, 0};
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, {31'd0, dut_if.out_valid}, {31'd0, exp_valid});
        check({tag, ".flags"}, {29'd0, dut_if.equal, dut_if.more, dut_if.less},
              {29'd0, exp_flags});
        check({tag, ".eq_cnt"},   {30'd0, eq_cnt},   exp_cnt[0]);
        check({tag, ".more_cnt"}, {30'd0, more_cnt}, exp_cnt[1]);
        check({tag, ".less_cnt"}, {30'd0, less_cnt}, exp_cnt[2]);
    endtask

    // One clock: fold the inputs present at the edge into the model, then compare.
    task automatic cycle(input string tag);
        int a_i, b_i, k;
        @(posedge clk);
        a_i = int'(dut_if.A);
        b_i = int'(dut_if.B);
        k   = -1;
        if (dut_if.in_valid) begin
            if (dut_if.casc_more)      k = 1;
            else if (dut_if.casc_less) k = 2;
            else if (a_i > b_i)        k = 1;
            else if (a_i < b_i)        k = 2;
            else                       k = 0;
            exp_flags = (k == 0) ? 3'b100 : (k == 1) ? 3'b010 : 3'b001;
        end
        exp_valid = dut_if.in_valid;
`ifdef CMP1BIT_STATS_EN
        if (clr_stats) begin
            exp_cnt = '{0, 0, 0};
        end else if (k >= 0 && exp_cnt[k] < int'(CMAX)) begin
            exp_cnt[k] = exp_cnt[k] + 1;
        end
`endif
        #1;
        check_outputs(tag);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        hi_if.in_valid = 0; hi_if.A = 0; hi_if.B = 0;
        hi_if.casc_more = 0; hi_if.casc_less = 0;
        lo_if.A = 0; lo_if.B = 0;

        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst = 1'b0;

        // Truth table with idle cascade.
        for (int i = 0; i < 4; i++) begin
            drive(1, i[1], i[0], 0, 0, 0);
            cycle("truth");
        end

        // Cascade overrides.
        drive(1, 0, 1, 1, 0, 0); cycle("casc_more");
        drive(1, 1, 0, 0, 1, 0); cycle("casc_less");
        drive(1, 1, 1, 1, 1, 0); cycle("casc_both");

        // Hold with in_valid low.
        drive(1, 1, 0, 0, 0, 0); cycle("hold_load");
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 1, 0);
            cycle("hold");
        end

        // Saturation then clear with a simultaneous sample.
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 1, 0, 0, 0);
            cycle("sat_eq");
        end
        drive(1, 0, 1, 0, 0, 1); cycle("clr_sample");
        drive(0, 0, 0, 0, 0, 0); cycle("after_clr");

        // Asynchronous reset between edges with a sample in flight.
        drive(1, 1, 0, 0, 0, 0);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(posedge clk);
        #1;
        check_outputs("rst_held");
        rst = 1'b0;
        drive(1, 0, 1, 0, 0, 0); cycle("post_rst");

        // Random stimulus.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 11) == 0));
            cycle("rand");
        end

        // Two-cell chain over all 16 (A,B) pairs; the DUT idles and must hold.
        drive(0, 0, 0, 0, 0, 0);
        for (int j = 0; j <= 16; j++) begin
            logic [3:0] cur, prv;
            cur = 4'(j);
            prv = 4'(j - 1);
            hi_if.in_valid = (j < 16);
            hi_if.A = cur[3];
            hi_if.B = cur[1];
            lo_if.A = prv[2];
            lo_if.B = prv[0];
            cycle("chain_idle");
            if (j >= 1) begin
                int a2, b2;
                logic [2:0] want;
                a2 = int'(prv[3:2]);
                b2 = int'(prv[1:0]);
                want = (a2 > b2) ? 3'b010 : (a2 < b2) ? 3'b001 : 3'b100;
                check("chain.valid", {31'd0, lo_if.out_valid}, 32'd1);
                check("chain.flags", {29'd0, lo_if.equal, lo_if.more, lo_if.less},
                      {29'd0, want});
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
